// File: rtl/usb_hub_pkg.sv
// Shared hub types: poller FSM states, event record,
// port status bit positions and default geometry.
package usb_hub_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int STATUS_W_DEF   = 8;
  localparam int TIMEOUT_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PORT_W_DEF     = $clog2(NUM_PORTS_DEF);

  localparam int CONNECT     = 0;
  localparam int ENABLE      = 1;
  localparam int SUSPEND     = 2;
  localparam int OVERCURRENT = 3;
  localparam int RESET       = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CMP,
    PUSH
  } poll_state_e;

  typedef struct packed {
    logic [PORT_W_DEF-1:0]   port;
    logic [STATUS_W_DEF-1:0] status;
  } evt_t;

endpackage

// File: rtl/port_status_poller_if.sv
// Poll request/ack bus to the port status mux and
// valid/ready event stream to the interrupt endpoint.
interface port_status_poller_if
  import usb_hub_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int STATUS_W  = STATUS_W_DEF
);
  localparam int PW = $clog2(NUM_PORTS);

  logic                poll_req;
  logic [PW-1:0]       poll_port;
  logic                poll_ack;
  logic [STATUS_W-1:0] poll_status;
  logic                evt_valid;
  logic                evt_ready;
  logic [PW-1:0]       evt_port;
  logic [STATUS_W-1:0] evt_status;

  modport master (
    output poll_req, poll_port,
    input  poll_ack, poll_status,
    output evt_valid, evt_port, evt_status,
    input  evt_ready
  );

  modport slave (
    input  poll_req, poll_port,
    output poll_ack, poll_status,
    input  evt_valid, evt_port, evt_status,
    output evt_ready
  );

endinterface

// File: rtl/port_evt_fifo.sv
// Synchronous FIFO with registered head data and
// registered full/empty flags.
module port_evt_fifo
  import usb_hub_pkg::*;
#(
  parameter int WIDTH = PORT_W_DEF + STATUS_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_en, rd_en;

  // Accept against registered flags; prefetch next head.
  always_comb begin
    wr_en   = push_i & ~full_q;
    rd_en   = pop_i & ~empty_q;
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(rd_en);
    cnt_d   = cnt_q + CW'(wr_en) - CW'(rd_en);
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
    if (wr_en && (wr_q == rd_d))
      dout_d = din_i;
    else
      dout_d = mem_q[rd_d];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem_q[wr_q] <= din_i;
  end

  // Pointers, count, flags and head register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/port_status_poller.sv
// Polls port status on tick edges, queues changes.
// Optional POLL_DEBOUNCE_EN: require two equal reads.
module port_status_poller
  import usb_hub_pkg::*;
#(
  parameter int NUM_PORTS      = NUM_PORTS_DEF,
  parameter int STATUS_W       = STATUS_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] poll_tick,
  port_status_poller_if.master bus,
  output logic [NUM_PORTS-1:0] change_bitmap,
  input  logic [NUM_PORTS-1:0] bitmap_clear,
  output logic                 timeout_err
);
  localparam int PW   = $clog2(NUM_PORTS);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST =
    CNTW'(TIMEOUT_CYCLES - 1);

  poll_state_e          state_q, state_d;
  logic [NUM_PORTS-1:0] tick_q;
  logic [NUM_PORTS-1:0] pend_q, pend_d, pend_clr;
  logic [PW-1:0]        port_q, port_d, low_idx;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [STATUS_W-1:0]  cap_q, cap_d;
  logic [STATUS_W-1:0]  shadow_q [NUM_PORTS];
  logic                 shadow_we;
  logic [NUM_PORTS-1:0] bitmap_q, bitmap_d, bitmap_set;
  logic                 tmo_q, tmo_d;
  logic                 push, differs;
  logic                 fifo_full, fifo_empty;
  logic [PW+STATUS_W-1:0] fifo_dout;
`ifdef POLL_DEBOUNCE_EN
  logic [STATUS_W-1:0]  cand_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand_vld_q;
  logic                 cand_we, cand_clr;
`endif

  // Lowest pending port wins arbitration.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (pend_q[i]) low_idx = PW'(i);
  end

  // Pending merge and sticky bitmap; set beats clear.
  always_comb begin
    pend_d   = (pend_q & ~pend_clr)
             | (poll_tick & ~tick_q);
    bitmap_d = (bitmap_q & ~bitmap_clear) | bitmap_set;
  end

  // Poll FSM next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    pend_clr   = '0;
    shadow_we  = 1'b0;
    bitmap_set = '0;
    tmo_d      = 1'b0;
    push       = 1'b0;
    differs    = (cap_q != shadow_q[port_q]);
`ifdef POLL_DEBOUNCE_EN
    cand_we    = 1'b0;
    cand_clr   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|pend_q) begin
          port_d            = low_idx;
          pend_clr[low_idx] = 1'b1;
          state_d           = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNTW'(1);
        if (bus.poll_ack) begin
          cap_d   = bus.poll_status;
          state_d = CMP;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CMP: begin
        state_d = IDLE;
`ifdef POLL_DEBOUNCE_EN
        if (!differs) begin
          cand_clr = 1'b1;
        end else if (cand_vld_q[port_q] &&
                     cand_q[port_q] == cap_q) begin
          shadow_we          = 1'b1;
          bitmap_set[port_q] = 1'b1;
          cand_clr           = 1'b1;
          state_d            = PUSH;
        end else begin
          cand_we = 1'b1;
        end
`else
        if (differs) begin
          shadow_we          = 1'b1;
          bitmap_set[port_q] = 1'b1;
          state_d            = PUSH;
        end
`endif
      end
      PUSH: begin
        push = 1'b1;
        if (!fifo_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      pend_q   <= '0;
      port_q   <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      bitmap_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= poll_tick;
      pend_q   <= pend_d;
      port_q   <= port_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      bitmap_q <= bitmap_d;
      tmo_q    <= tmo_d;
    end
  end

  // Per-port shadow of the last accepted status.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[port_q] <= cap_q;
    end
  end

`ifdef POLL_DEBOUNCE_EN
  // Candidate reading awaiting confirmation.
  always_ff @(posedge clock) begin
    if (reset) begin
      cand_vld_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++)
        cand_q[i] <= '0;
    end else if (cand_we) begin
      cand_q[port_q]     <= cap_q;
      cand_vld_q[port_q] <= 1'b1;
    end else if (cand_clr) begin
      cand_vld_q[port_q] <= 1'b0;
    end
  end
`endif

  port_evt_fifo #(
    .WIDTH (PW + STATUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({port_q, cap_q}),
    .pop_i   (bus.evt_ready),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.poll_req   = (state_q == REQ);
  assign bus.poll_port  = port_q;
  assign bus.evt_valid  = ~fifo_empty;
  assign {bus.evt_port, bus.evt_status} = fifo_dout;
  assign change_bitmap  = bitmap_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_port_status_poller.sv
// Directed bench for port_status_poller: vector table
// plus backpressure, clear race and reset sequences.
module tb_port_status_poller;
  import usb_hub_pkg::*;

  localparam int NP = 4;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [NP-1:0] poll_tick;
  logic [NP-1:0] change_bitmap;
  logic [NP-1:0] bitmap_clear;
  logic          timeout_err;

  port_status_poller_if #(
    .NUM_PORTS(NP), .STATUS_W(SW)
  ) bus ();

  port_status_poller #(
    .NUM_PORTS(NP), .STATUS_W(SW),
    .TIMEOUT_CYCLES(16), .FIFO_DEPTH(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .poll_tick     (poll_tick),
    .bus           (bus),
    .change_bitmap (change_bitmap),
    .bitmap_clear  (bitmap_clear),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            port;
    logic [SW-1:0] status;
    logic          evt;
    logic          tmo;
    logic [NP-1:0] bmp;
  } vec_t;

  vec_t    vecs [7];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  logic [NP-1:0] ack_en;
  logic [SW-1:0] resp [NP];
  logic    force_ack;
  int      ack_cyc, evt_rise_cyc, req_rise_cyc, tmo_cyc;
  int      req_rises = 0;
  int      tmo_cnt = 0;
  logic    evt_prev = 1'b0;
  logic    req_prev = 1'b0;
  evt_t    popped [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick(input int p);
    poll_tick = '0;
    step(1);
    poll_tick = NP'(1) << p;
  endtask

  // Status mux model: acks on the first request cycle.
  initial begin
    bus.poll_ack    = 1'b0;
    bus.poll_status = '0;
    forever begin
      @(posedge clock);
      #1;
      if (force_ack) begin
        bus.poll_ack    = 1'b1;
        bus.poll_status = 8'hAA;
      end else if (bus.poll_req && !bus.poll_ack &&
                   ack_en[bus.poll_port]) begin
        bus.poll_ack    = 1'b1;
        bus.poll_status = resp[bus.poll_port];
        ack_cyc         = cyc;
      end else begin
        bus.poll_ack = 1'b0;
      end
    end
  end

  // Observe pops, rises and timeout pulses mid-cycle.
  always @(negedge clock) begin
    if (bus.evt_valid && bus.evt_ready)
      popped.push_back({bus.evt_port, bus.evt_status});
    if (bus.evt_valid && !evt_prev)
      evt_rise_cyc = cyc;
    if (bus.poll_req && !req_prev) begin
      req_rise_cyc = cyc;
      req_rises++;
    end
    if (timeout_err) begin
      tmo_cyc = cyc;
      tmo_cnt++;
    end
    evt_prev = bus.evt_valid;
    req_prev = bus.poll_req;
  end

  initial begin
    int   base, tbase, rb;
    logic got;
    evt_t e;
    int   bp_port [5];
    logic [SW-1:0] bp_st [5];

    reset         = 1'b1;
    poll_tick     = '0;
    bitmap_clear  = '0;
    bus.evt_ready = 1'b1;
    force_ack     = 1'b0;
    ack_en        = 4'b1011;
    for (int i = 0; i < NP; i++) resp[i] = '0;

    vecs[0] = '{0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{1, 8'(1 << CONNECT),
                1'b1, 1'b0, 4'b0010};
    vecs[2] = '{1, 8'(1 << CONNECT),
                1'b0, 1'b0, 4'b0010};
    vecs[3] = '{3, 8'((1 << CONNECT) | (1 << OVERCURRENT)),
                1'b1, 1'b0, 4'b1010};
    vecs[4] = '{1, 8'((1 << CONNECT) | (1 << ENABLE)),
                1'b1, 1'b0, 4'b1010};
    vecs[5] = '{2, 8'h00, 1'b0, 1'b1, 4'b1010};
    vecs[6] = '{0, 8'(1 << RESET),
                1'b1, 1'b0, 4'b1011};

    step(3);
    reset = 1'b0;
    chk("rst_poll_req", bus.poll_req, 0);
    chk("rst_poll_port", bus.poll_port, 0);
    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_evt_data",
        {bus.evt_port, bus.evt_status}, 0);
    chk("rst_bitmap", change_bitmap, 0);
    chk("rst_timeout", timeout_err, 0);

    for (int k = 0; k < 7; k++) begin
      base  = popped.size();
      tbase = tmo_cnt;
      resp[vecs[k].port] = vecs[k].status;
      tick(vecs[k].port);
      step(26);
      chk($sformatf("v%0d_bitmap", k),
          change_bitmap, vecs[k].bmp);
      chk($sformatf("v%0d_idle", k), bus.poll_req, 0);
      chk($sformatf("v%0d_tmo_pulses", k),
          tmo_cnt - tbase, vecs[k].tmo);
      chk($sformatf("v%0d_evt_count", k),
          popped.size() - base, vecs[k].evt);
      if (vecs[k].evt && popped.size() > base) begin
        e.port   = PORT_W_DEF'(vecs[k].port);
        e.status = vecs[k].status;
        chk($sformatf("v%0d_evt", k), popped[base], e);
        chk($sformatf("v%0d_evt_lat", k),
            evt_rise_cyc - ack_cyc, 3);
      end
      if (vecs[k].tmo)
        chk($sformatf("v%0d_tmo_delay", k),
            tmo_cyc - req_rise_cyc, 16);
    end

    bitmap_clear = '1;
    step(1);
    bitmap_clear = '0;
    chk("bitmap_clear_all", change_bitmap, 0);

    bus.evt_ready = 1'b0;
    ack_en[2]     = 1'b1;
    base          = popped.size();
    bp_port = '{0, 1, 2, 3, 0};
    bp_st   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03};
    for (int j = 0; j < 5; j++) begin
      resp[bp_port[j]] = bp_st[j];
      tick(bp_port[j]);
      step(12);
    end
    chk("bp_valid", bus.evt_valid, 1);
    chk("bp_head", {bus.evt_port, bus.evt_status},
        {2'd0, 8'h01});
    chk("bp_bitmap", change_bitmap, 4'b1111);
    chk("bp_no_pop", popped.size() - base, 0);
    rb = req_rises;
    tick(1);
    step(3);
    tick(1);
    step(15);
    chk("bp_stall_no_req", req_rises - rb, 0);
    bus.evt_ready = 1'b1;
    step(30);
    chk("bp_evt_count", popped.size() - base, 5);
    for (int j = 0; j < 5; j++) begin
      if (popped.size() > base + j) begin
        e.port   = PORT_W_DEF'(bp_port[j]);
        e.status = bp_st[j];
        chk($sformatf("bp_evt%0d", j),
            popped[base + j], e);
      end
    end
    chk("bp_merged_polls", req_rises - rb, 1);
    chk("bp_drained", bus.evt_valid, 0);

    bitmap_clear = 4'b0001;
    step(1);
    bitmap_clear = '0;
    chk("race_pre_clear", change_bitmap, 4'b1110);
    resp[0] = 8'h05;
    tick(0);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clock);
      #2;
      got = bus.poll_ack;
    end
    chk("race_ack_seen", got, 1);
    @(posedge clock);
    #2 bitmap_clear = 4'b0001;
    @(posedge clock);
    #2 bitmap_clear = '0;
    chk("race_set_wins", change_bitmap, 4'b1111);
    step(10);
    e.port   = 2'd0;
    e.status = 8'h05;
    chk("race_evt", popped[popped.size() - 1], e);

    ack_en[3] = 1'b0;
    tick(3);
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      step(1);
      got = bus.poll_req;
    end
    chk("rst_mid_req_seen", got, 1);
    reset     = 1'b1;
    poll_tick = '0;
    step(1);
    chk("rst_mid_req_drop", bus.poll_req, 0);
    reset = 1'b0;
    chk("rst_mid_bitmap", change_bitmap, 0);
    chk("rst_mid_fifo", bus.evt_valid, 0);
    base  = popped.size();
    tbase = tmo_cnt;
    rb    = req_rises;
    #1 force_ack = 1'b1;
    @(posedge clock);
    #2 force_ack = 1'b0;
    step(5);
    chk("late_ack_req", bus.poll_req, 0);
    chk("late_ack_no_evt", popped.size() - base, 0);
    chk("late_ack_bitmap", change_bitmap, 0);
    chk("late_ack_no_tmo", tmo_cnt - tbase, 0);
    ack_en[3] = 1'b1;
    resp[1]   = 8'h00;
    resp[3]   = 8'h00;
    tick(1);
    step(12);
    tick(3);
    step(12);
    chk("shadow_zero_evt", popped.size() - base, 0);
    chk("shadow_zero_bmp", change_bitmap, 0);
    chk("shadow_zero_polls", req_rises - rb, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/port_status_poller.md
Name: port_status_poller

Overview:
- Consumes the one-hot rotating polling strobes from the hub's polling clock generator.
- On each strobe it reads the addressed downstream port's status over a req/ack handshake and compares the result against a per-port shadow copy.
- It reports changes two ways: as queued events for the upstream interrupt endpoint, and as a sticky hub status-change bitmap.

Parameters:
- NUM_PORTS, 4, number of downstream ports; width of poll_tick. Must be >= 2.
- STATUS_W, 8, width of one port status word.
- TIMEOUT_CYCLES, 16, maximum number of cycles poll_req waits for poll_ack.
- FIFO_DEPTH, 4, entries in the event FIFO. Power of two.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- poll_tick  in  NUM_PORTS  one-hot level strobes from the polling clock generator. Each bit is held for many cycles, then rotates.
- poll_req  out  1  request to the port status mux.
- poll_port  out  $clog2(NUM_PORTS)  index of the port being polled. Stable while poll_req is high.
- poll_ack  in  1  one-cycle acknowledge; poll_status is valid in the same cycle.
- poll_status  in  STATUS_W  status word of poll_port.
- evt_valid  out  1  event FIFO is non-empty.
- evt_ready  in  1  consumer pops the head entry when evt_valid and evt_ready are both high.
- evt_port  out  $clog2(NUM_PORTS)  port index of the head event.
- evt_status  out  STATUS_W  new status of the head event.
- change_bitmap  out  NUM_PORTS  sticky per-port change flags.
- bitmap_clear  in  NUM_PORTS  per-bit clear of change_bitmap.
- timeout_err  out  1  one-cycle pulse when a poll times out.

Behaviour:
- Reset: all outputs 0; shadow status per port 0; pending mask 0; FIFO empty; FSM in IDLE. Reset asserted mid-poll drops poll_req in the next cycle and discards the in-flight poll.
- Tick detection: rising edge per bit of poll_tick, using a registered copy of the previous value. An edge sets pending[i]. An edge on a port that is already pending is merged, not counted twice.
- FSM states:
  - IDLE: if pending != 0, select the lowest set index, clear its pending bit, load poll_port, go to REQ. poll_req rises one cycle later.
  - REQ: poll_req = 1. The timeout counter counts cycles with poll_req high.
    - poll_ack: capture poll_status, go to CMP.
    - Counter reaches TIMEOUT_CYCLES with no ack: pulse timeout_err, leave the shadow unchanged, raise no event, return to IDLE.
    - poll_ack in the same cycle the counter reaches the limit counts as success.
  - CMP: one cycle.
    - Captured value == shadow: return to IDLE.
    - Otherwise: update the shadow, set change_bitmap[port], go to PUSH.
  - PUSH: write {port, status} to the FIFO when it is not full, then go to IDLE. While the FIFO is full, stay in PUSH; poll_req stays low and ticks keep accumulating in pending.
- Latency:
  - tick edge in cycle T -> poll_req high in T+2 (edge register, then IDLE decision).
  - poll_ack in cycle A -> FIFO write in A+2 if not full -> evt_valid high in A+3 if the FIFO was empty.
- FIFO:
  - FIFO read data is registered output.
  - Simultaneous push and pop when full: push is held, as the full flag is registered.
  - Simultaneous push and pop when empty: the pushed entry appears in the next cycle.
- change_bitmap: a set and a bitmap_clear on the same bit in the same cycle -> the set wins. Set is independent of FIFO occupancy.
- poll_port wraps naturally. Pending bits with index >= NUM_PORTS do not exist.

Optional Feature:
- Macro: POLL_DEBOUNCE_EN.
- Defined: a change is accepted only after two consecutive successful polls of the same port return an identical value that differs from the shadow. A per-port candidate register and valid flag are held. A differing first reading only loads the candidate; no event and no bitmap set. A reading equal to the shadow clears the candidate.
- Undefined: the first differing reading is reported, as described above.

Decomposition:
- Shared package usb_hub_pkg holds:
  - FSM state enum (IDLE, REQ, CMP, PUSH).
  - Event struct {port, status}.
  - Status bit-position constants: CONNECT, ENABLE, SUSPEND, OVERCURRENT, RESET.
- One sub-module: port_evt_fifo, a synchronous FIFO parameterised by width and depth, with full/empty flags.

Test Plan:
- Tick rotation: poll_tick 0001 -> 0010. Port 1 acks status 0x01. Result: evt {port 1, 0x01}; change_bitmap = 0010; evt_valid rises 3 cycles after ack.
- No-change poll: repeat the tick on port 1 with 0x01. Result: no event; bitmap unchanged.
- Timeout: port 2 never acks. Result: timeout_err pulses exactly TIMEOUT_CYCLES = 16 cycles after poll_req rises; no event; FSM back in IDLE.
- Backpressure: hold evt_ready = 0 and produce 5 changes with FIFO_DEPTH = 4. Result: 4 entries queued; FSM stalls in PUSH. Raise evt_ready: the fifth event is delivered, in order, with none lost.
- Clear race: bitmap_clear = 0001 in the same cycle port 0 sets its bit. Result: change_bitmap[0] stays 1.
- Reset mid-poll: assert reset while poll_req is high. Result: poll_req is 0 in the next cycle; shadows 0; FIFO empty; a later ack is ignored.
